// File: rtl/mem_slave_pkg.sv
// Shared constants and types for the memory slave responder.
package mem_slave_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic ASSERTED_N   = 1'b0;
   localparam logic DEASSERTED_N = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_WAIT = S_WAIT,
      ST_ACK  = S_ACK,
      ST_DONE = S_DONE
   } slv_state_e;

   // Wait counter width; at least one bit even when no wait states are used.
   function automatic int cnt_width(input int wait_states);
      return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
   endfunction

endpackage

// File: rtl/mem_slave_ram.sv
// Synchronous single-port word RAM; contents are deliberately not reset.
module mem_slave_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write on we; read data register only updates on re so it holds between reads.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_slave_ctrl.sv
// Bus-side memory responder: captures an AS_N request, inserts wait states,
// pulses ACK_N for one cycle and serves the access from an internal RAM.
//
// state | meaning
// IDLE  | waiting for AS_N low; captures address, data and direction
// WAIT  | counting wait states; AS_N high aborts the transfer
// ACK   | ACK_N low for one cycle; RAM accessed on the edge entering it
// DONE  | waiting for the controller to release AS_N
module mem_slave_ctrl
   import mem_slave_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              AS_N,
   input  logic              WR_N,
   input  logic [AW-1:0]     ADDR,
   input  logic [DATA_W-1:0] DIN,
   output logic              ACK_N,
   output logic [DATA_W-1:0] DOUT,
   output logic [1:0]        SLV_STATE
);

   localparam int CW = cnt_width(WAIT_STATES);
   localparam logic [CW-1:0] WS_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

   slv_state_e        state_q, state_nx;
   logic [CW-1:0]     cnt_q;
   logic [AW-1:0]     addr_q;
   logic [DATA_W-1:0] din_q;
   logic              wr_n_q;
   logic              dout_vld_q;

   logic              cap;
   logic              cnt_load;
   logic              cnt_dec;
   logic              go_ack;

   logic [AW-1:0]     ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_wr_n;
   logic              ram_we;
   logic              ram_re;
   logic [DATA_W-1:0] ram_rdata;

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Next-state and control strobes.
   always_comb begin
      state_nx = state_q;
      cap      = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      go_ack   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (AS_N == ASSERTED_N) begin
               cap = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nx = ST_ACK;
                  go_ack   = 1'b1;
               end else begin
                  state_nx = ST_WAIT;
                  cnt_load = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (AS_N == DEASSERTED_N) begin
               state_nx = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_nx = ST_ACK;
               go_ack   = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_ACK: begin
            state_nx = ST_DONE;
         end
         ST_DONE: begin
            if (AS_N == DEASSERTED_N) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Wait-state down-counter.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else if (cnt_load) begin
         cnt_q <= WS_LOAD;
      end else if (cnt_dec) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // Request capture; later bus changes cannot disturb the transfer.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         addr_q <= '0;
         din_q  <= '0;
         wr_n_q <= 1'b0;
      end else if (cap) begin
         addr_q <= ADDR;
         din_q  <= DIN;
         wr_n_q <= WR_N;
      end
   end

   // With zero wait states ACK is entered straight from IDLE, so the RAM must
   // see the live bus in that cycle instead of the not-yet-captured request.
   always_comb begin
      ram_addr  = addr_q;
      ram_wdata = din_q;
      ram_wr_n  = wr_n_q;
      if (state_q == ST_IDLE) begin
         ram_addr  = ADDR;
         ram_wdata = DIN;
         ram_wr_n  = WR_N;
      end
      ram_we = go_ack && (ram_wr_n == ASSERTED_N);
      ram_re = go_ack && (ram_wr_n == DEASSERTED_N);
   end

   // Registered acknowledge and the read-seen flag that unmasks DOUT.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ACK_N      <= DEASSERTED_N;
         dout_vld_q <= 1'b0;
      end else begin
         ACK_N <= go_ack ? ASSERTED_N : DEASSERTED_N;
         if (ram_re) begin
            dout_vld_q <= 1'b1;
         end
      end
   end

   mem_slave_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // RAM has no reset, so DOUT reads as zero until the first read lands.
   assign DOUT      = dout_vld_q ? ram_rdata : '0;
   assign SLV_STATE = state_q;

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Randomised bench for mem_slave_ctrl: three instances (2, 0 and 3 wait states)
// share one bus; a selector routes AS_N to the instance under test.
module tb_mem_slave_ctrl;

   localparam int DW = 32;
   localparam int AW = 8;

   int ws_tab [3] = '{2, 0, 3};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          as_n = 1'b1;
   logic          wr_n = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] din = '0;
   int            sel = 0;

   logic          as_v   [3];
   logic          ack_w  [3];
   logic [DW-1:0] dout_w [3];
   logic [1:0]    st_w   [3];

   logic [DW-1:0] mem_m  [3][256];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign as_v[0] = (sel == 0) ? as_n : 1'b1;
   assign as_v[1] = (sel == 1) ? as_n : 1'b1;
   assign as_v[2] = (sel == 2) ? as_n : 1'b1;

   mem_slave_ctrl #(.DATA_W(DW), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
      .CLK(clk), .RESET_N(rst_n), .AS_N(as_v[0]), .WR_N(wr_n), .ADDR(addr), .DIN(din),
      .ACK_N(ack_w[0]), .DOUT(dout_w[0]), .SLV_STATE(st_w[0]));

   mem_slave_ctrl #(.DATA_W(DW), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
      .CLK(clk), .RESET_N(rst_n), .AS_N(as_v[1]), .WR_N(wr_n), .ADDR(addr), .DIN(din),
      .ACK_N(ack_w[1]), .DOUT(dout_w[1]), .SLV_STATE(st_w[1]));

   mem_slave_ctrl #(.DATA_W(DW), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
      .CLK(clk), .RESET_N(rst_n), .AS_N(as_v[2]), .WR_N(wr_n), .ADDR(addr), .DIN(din),
      .ACK_N(ack_w[2]), .DOUT(dout_w[2]), .SLV_STATE(st_w[2]));

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One full handshake, entered and left at a negedge. Latency, ack width,
   // read data and return to IDLE are all compared against the model.
   task automatic xfer(input int inst, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit scramble, output time t_e0);
      int n;
      sel  = inst;
      as_n = 1'b0;
      wr_n = ~wr;
      addr = a;
      din  = d;
      n    = 0;
      t_e0 = 0;
      do begin
         @(posedge clk);
         if (n == 0) t_e0 = $time;
         n++;
         @(negedge clk);
         if (scramble) begin
            addr = AW'($urandom);
            din  = $urandom;
         end
      end while (ack_w[inst] !== 1'b0 && n < 20);
      chk($sformatf("latency i%0d", inst), n, ws_tab[inst] + 1);
      if (!wr) chk($sformatf("rdata i%0d a%0d", inst, a), dout_w[inst], mem_m[inst][a]);
      else     mem_m[inst][a] = d;
      as_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ack_width i%0d", inst), ack_w[inst], 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("back_idle i%0d", inst), st_w[inst], 2'd0);
   endtask

   // Write request released after 'hold' edges; must never be acknowledged.
   task automatic abort_wr(input int inst, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int hold);
      bit seen;
      seen = 1'b0;
      sel  = inst;
      as_n = 1'b0;
      wr_n = 1'b0;
      addr = a;
      din  = d;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ack_w[inst] === 1'b0) seen = 1'b1;
      end
      as_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ack_w[inst] === 1'b0) seen = 1'b1;
      end
      chk($sformatf("abort_no_ack i%0d", inst), seen, 1'b0);
      chk($sformatf("abort_idle i%0d", inst), st_w[inst], 2'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      time t0, t1, t2, tx;
      logic [DW-1:0] old;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_ack i%0d", i), ack_w[i], 1'b1);
         chk($sformatf("rst_dout i%0d", i), dout_w[i], '0);
         chk($sformatf("rst_state i%0d", i), st_w[i], 2'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Known contents in words 0..15 of every instance.
      for (int i = 0; i < 3; i++)
         for (int a = 0; a < 16; a++)
            xfer(i, 1'b1, AW'(a), $urandom, 1'b0, tx);

      // Write then read with two wait states.
      xfer(0, 1'b1, 8'd5, 32'hDEADBEEF, 1'b0, tx);
      xfer(0, 1'b0, 8'd5, 32'h0, 1'b0, tx);
      chk("deadbeef", dout_w[0], 32'hDEADBEEF);

      // Zero wait states: back-to-back reads, period 3 cycles.
      xfer(1, 1'b0, 8'd0, 32'h0, 1'b0, t0);
      xfer(1, 1'b0, 8'd1, 32'h0, 1'b0, t1);
      xfer(1, 1'b0, 8'd2, 32'h0, 1'b0, t2);
      chk("period01", DW'((t1 - t0) / 10), 32'd3);
      chk("period12", DW'((t2 - t1) / 10), 32'd3);

      // Abort mid-wait, and abort in the cycle the counter hits zero.
      abort_wr(2, 8'd9, 32'h12345678, 2);
      xfer(2, 1'b0, 8'd9, 32'h0, 1'b0, tx);
      abort_wr(0, 8'd10, 32'hA5A5A5A5, 2);
      xfer(0, 1'b0, 8'd10, 32'h0, 1'b0, tx);

      // Bus wiggles during the wait must not affect the captured request.
      xfer(2, 1'b1, 8'd7, 32'hCAFEF00D, 1'b1, tx);
      xfer(2, 1'b0, 8'd7, 32'h0, 1'b0, tx);

      // Asynchronous reset while waiting.
      old  = mem_m[0][3];
      sel  = 0;
      as_n = 1'b0;
      wr_n = 1'b0;
      addr = 8'd3;
      din  = ~old;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_wait", st_w[0], 2'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_ack", ack_w[0], 1'b1);
      chk("async_dout", dout_w[0], '0);
      chk("async_state", st_w[0], 2'd0);
      as_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      xfer(0, 1'b0, 8'd3, 32'h0, 1'b0, tx);
      chk("rst_no_commit", dout_w[0], old);
      xfer(0, 1'b1, 8'd4, 32'h600DD00D, 1'b0, tx);
      xfer(0, 1'b0, 8'd4, 32'h0, 1'b0, tx);

      // Random traffic against the reference memories.
      for (int k = 0; k < 48; k++) begin
         xfer(int'($urandom_range(0, 2)), 1'($urandom), AW'($urandom_range(0, 15)),
              $urandom, 1'b0, tx);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
